// File: rtl/phase_scan_pkg.sv
// Shared definitions for the phase scan sequencer.
// Contents: FSM state enum, step width, default parameter values and a
// helper that turns a zero step increment into one.
package phase_scan_pkg;

   localparam int unsigned STEP_W      = 6;
   localparam int unsigned RST_LEN_DEF = 4;
   localparam int unsigned DWELL_W_DEF = 16;

   typedef enum logic [2:0] {
      IDLE,
      RST_PULSE,
      SETTLE,
      ADVANCE,
      FINISH
   } state_e;

   // A zero increment would stall the scan on one phase; step by one instead.
   function automatic logic [STEP_W-1:0] step_inc_eff(input logic [STEP_W-1:0] inc);
      return (inc == '0) ? STEP_W'(1) : inc;
   endfunction

endpackage

// File: rtl/scan_dwell_timer.sv
// Loadable down-counter shared by the reset-pulse and settle phases.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   load_i         load load_val_i (wins over counting)
//   en_i           decrement while non-zero
//   load_val_i     cycle count of the phase being entered (>= 1)
//   tc_c_o         combinational: current cycle is the last of the phase
//   pre_tc_c_o     combinational: next cycle is the last of the phase
module scan_dwell_timer
   import phase_scan_pkg::*;
#(
   parameter int unsigned CNT_W = DWELL_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             tc_c_o,
   output logic             pre_tc_c_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: load has priority, otherwise count down and stop at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_c_o     = (cnt_q == CNT_W'(1));
   assign pre_tc_c_o = (cnt_q == CNT_W'(2));

endmodule

// File: rtl/phase_scan_ctrl.sv
// Phase scan sequencer for the control-signal regenerator.
// Steps the phase offset NSTEP1 from STEP_MIN to STEP_MAX, pulsing REGEN_RST
// at every step, waiting a dwell window and then strobing STEP_VALID once.
// Build option: define PHASE_SCAN_LOOP_EN to wrap back to STEP_MIN instead
// of finishing, repeating until ABORT.
// Ports:
//   CLK_IN, RST_IN          100 MHz clock, synchronous active-high reset
//   START, ABORT            scan start request / stop scan
//   STEP_MIN/MAX/INC        scan range and increment (INC 0 acts as 1)
//   DWELL                   settle cycles per step (0 acts as 1)
//   CNV_STRETCH             stretch length, forwarded on NSTEP2
//   NSTEP1, NSTEP2          phase offset and stretch to the regenerator
//   REGEN_RST               regenerator reset, RST_LEN cycles per step
//   STEP_VALID              one-cycle strobe on the last settle cycle
//   STEP_IDX                0-based index of the current step
//   BUSY, DONE, ERR         scan running / sticky complete / sticky range error
module phase_scan_ctrl
   import phase_scan_pkg::*;
#(
   parameter int unsigned RST_LEN = RST_LEN_DEF,
   parameter int unsigned DWELL_W = DWELL_W_DEF
) (
   input  logic               CLK_IN,
   input  logic               RST_IN,
   input  logic               START,
   input  logic               ABORT,
   input  logic [STEP_W-1:0]  STEP_MIN,
   input  logic [STEP_W-1:0]  STEP_MAX,
   input  logic [STEP_W-1:0]  STEP_INC,
   input  logic [DWELL_W-1:0] DWELL,
   input  logic [STEP_W-1:0]  CNV_STRETCH,
   output logic [STEP_W-1:0]  NSTEP1,
   output logic [STEP_W-1:0]  NSTEP2,
   output logic               REGEN_RST,
   output logic               STEP_VALID,
   output logic [STEP_W-1:0]  STEP_IDX,
   output logic               BUSY,
   output logic               DONE,
   output logic               ERR
);

   // Timer must hold both the reset length (up to 255) and the dwell.
   localparam int unsigned CNT_W = (DWELL_W > 8) ? DWELL_W : 8;

   state_e              state_q, state_d;
   logic [STEP_W-1:0]   nstep1_q, nstep1_d;
   logic [STEP_W-1:0]   nstep2_q, nstep2_d;
   logic [STEP_W-1:0]   idx_q, idx_d;
   logic                regen_q, regen_d;
   logic                valid_q, valid_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [STEP_W-1:0]   max_q, max_d;
   logic [STEP_W-1:0]   inc_q, inc_d;
   logic [DWELL_W-1:0]  dwell_q, dwell_d;
`ifdef PHASE_SCAN_LOOP_EN
   logic [STEP_W-1:0]   min_q, min_d;
`endif

   logic                tmr_load_c;
   logic [CNT_W-1:0]    tmr_val_c;
   logic                tmr_en_c;
   logic                tmr_tc_c;
   logic                tmr_pre_tc_c;
   // One extra bit so an increment past 63 still compares above STEP_MAX.
   logic [STEP_W:0]     next_step_c;

   assign tmr_en_c    = (state_q == RST_PULSE) || (state_q == SETTLE);
   assign next_step_c = {1'b0, nstep1_q} + {1'b0, inc_q};

   scan_dwell_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk_i      (CLK_IN),
      .rst_i      (RST_IN),
      .load_i     (tmr_load_c),
      .en_i       (tmr_en_c),
      .load_val_i (tmr_val_c),
      .tc_c_o     (tmr_tc_c),
      .pre_tc_c_o (tmr_pre_tc_c)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d    = state_q;
      nstep1_d   = nstep1_q;
      nstep2_d   = nstep2_q;
      idx_d      = idx_q;
      regen_d    = regen_q;
      valid_d    = 1'b0;
      busy_d     = busy_q;
      done_d     = done_q;
      err_d      = err_q;
      max_d      = max_q;
      inc_d      = inc_q;
      dwell_d    = dwell_q;
`ifdef PHASE_SCAN_LOOP_EN
      min_d      = min_q;
`endif
      tmr_load_c = 1'b0;
      tmr_val_c  = '0;

      if (ABORT && (state_q != IDLE)) begin
         // Abort leaves DONE untouched and holds the phase where it is.
         state_d = IDLE;
         busy_d  = 1'b0;
         regen_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (START && !ABORT) begin
                  max_d   = STEP_MAX;
                  inc_d   = step_inc_eff(STEP_INC);
                  dwell_d = (DWELL == '0) ? DWELL_W'(1) : DWELL;
`ifdef PHASE_SCAN_LOOP_EN
                  min_d   = STEP_MIN;
`endif
                  if (STEP_MIN > STEP_MAX) begin
                     err_d   = 1'b1;
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     state_d = FINISH;
                  end else begin
                     err_d      = 1'b0;
                     done_d     = 1'b0;
                     nstep1_d   = STEP_MIN;
                     nstep2_d   = CNV_STRETCH;
                     idx_d      = '0;
                     busy_d     = 1'b1;
                     regen_d    = 1'b1;
                     tmr_load_c = 1'b1;
                     tmr_val_c  = CNT_W'(RST_LEN);
                     state_d    = RST_PULSE;
                  end
               end
            end

            RST_PULSE: begin
               if (tmr_tc_c) begin
                  regen_d    = 1'b0;
                  tmr_load_c = 1'b1;
                  tmr_val_c  = CNT_W'(dwell_q);
                  // A one-cycle dwell makes the first settle cycle the strobe cycle.
                  valid_d    = (dwell_q == DWELL_W'(1));
                  state_d    = SETTLE;
               end
            end

            SETTLE: begin
               // Register the strobe one cycle early so it lines up with the last settle cycle.
               valid_d = tmr_pre_tc_c;
               if (tmr_tc_c) begin
                  state_d = ADVANCE;
               end
            end

            ADVANCE: begin
               if (next_step_c > {1'b0, max_q}) begin
`ifdef PHASE_SCAN_LOOP_EN
                  nstep1_d   = min_q;
                  idx_d      = '0;
                  regen_d    = 1'b1;
                  tmr_load_c = 1'b1;
                  tmr_val_c  = CNT_W'(RST_LEN);
                  state_d    = RST_PULSE;
`else
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = FINISH;
`endif
               end else begin
                  nstep1_d   = next_step_c[STEP_W-1:0];
                  idx_d      = idx_q + STEP_W'(1);
                  regen_d    = 1'b1;
                  tmr_load_c = 1'b1;
                  tmr_val_c  = CNT_W'(RST_LEN);
                  state_d    = RST_PULSE;
               end
            end

            FINISH: begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge CLK_IN) begin
      if (RST_IN) begin
         state_q  <= IDLE;
         nstep1_q <= '0;
         nstep2_q <= '0;
         idx_q    <= '0;
         regen_q  <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         max_q    <= '0;
         inc_q    <= '0;
         dwell_q  <= '0;
`ifdef PHASE_SCAN_LOOP_EN
         min_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         nstep1_q <= nstep1_d;
         nstep2_q <= nstep2_d;
         idx_q    <= idx_d;
         regen_q  <= regen_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         max_q    <= max_d;
         inc_q    <= inc_d;
         dwell_q  <= dwell_d;
`ifdef PHASE_SCAN_LOOP_EN
         min_q    <= min_d;
`endif
      end
   end

   assign NSTEP1     = nstep1_q;
   assign NSTEP2     = nstep2_q;
   assign STEP_IDX   = idx_q;
   assign REGEN_RST  = regen_q;
   assign STEP_VALID = valid_q;
   assign BUSY       = busy_q;
   assign DONE       = done_q;
   assign ERR        = err_q;

endmodule

// File: doc/phase_scan_ctrl.md
Name: phase_scan_ctrl

Overview:
Upstream sequencer for regenerate_ctrl_signal. It steps the 2 MHz clock phase offset (NSTEP1) through a programmed range. At each step it pulses the regenerator reset to re-align the phase, then waits a dwell window. At the end of the window it emits a one-cycle strobe so downstream capture logic can sample at that phase. It also drives a latched CNVCLK stretch length (NSTEP2). Runs in the 100 MHz CLK_IN domain.

Parameters:
RST_LEN, 4, cycles REGEN_RST is held high per step (1..255)
DWELL_W, 16, width of DWELL input / dwell counter

Ports:
CLK_IN  input  1  100 MHz clock
RST_IN  input  1  reset, synchronous, active-high
START  input  1  one-cycle scan start request
ABORT  input  1  stop scan, return to IDLE
STEP_MIN  input  6  first NSTEP1 value
STEP_MAX  input  6  last allowed NSTEP1 value
STEP_INC  input  6  NSTEP1 increment per step (0 treated as 1)
DWELL  input  DWELL_W  settle cycles per step
CNV_STRETCH  input  6  CNVCLK stretch length, latched at START
NSTEP1  output  6  phase offset to regenerator
NSTEP2  output  6  stretch length to regenerator
REGEN_RST  output  1  reset to regenerator RST_IN
STEP_VALID  output  1  one-cycle strobe at end of each dwell
STEP_IDX  output  6  index of current step (0-based)
BUSY  output  1  scan in progress
DONE  output  1  sticky scan complete; cleared by next START
ERR  output  1  sticky range error (STEP_MIN > STEP_MAX); cleared by next START

Behaviour:
- Reset values: all outputs 0. State IDLE. Reset is honoured mid-scan and overrides everything.
- States: IDLE, RST_PULSE, SETTLE, ADVANCE, FINISH.
- IDLE:
  - START sampled at cycle 0: latch STEP_MIN/MAX/INC, DWELL and CNV_STRETCH; clear DONE and ERR.
  - If STEP_MIN > STEP_MAX: set ERR, go FINISH.
  - Otherwise, from cycle 1: NSTEP1=STEP_MIN, NSTEP2=CNV_STRETCH, STEP_IDX=0, BUSY=1, REGEN_RST=1, go RST_PULSE.
- RST_PULSE: REGEN_RST stays high for exactly RST_LEN cycles, then SETTLE.
- SETTLE:
  - Count DWELL cycles; DWELL=0 behaves as 1.
  - On the last settle cycle STEP_VALID=1 for exactly one cycle; NSTEP1 and STEP_IDX are stable while it is high.
  - Then go ADVANCE.
- ADVANCE (1 cycle):
  - Compute next = NSTEP1 + max(INC,1) in 7 bits.
  - If next > latched STEP_MAX (this includes 6-bit overflow): go FINISH.
  - Else NSTEP1=next, STEP_IDX+1, REGEN_RST=1, go RST_PULSE.
- FINISH (1 cycle): BUSY=0, DONE=1 (also when ERR), go IDLE. NSTEP1/NSTEP2 hold their last values.
- START while BUSY: ignored.
- ABORT:
  - Any non-IDLE state goes to IDLE next cycle: BUSY=0, REGEN_RST=0, no STEP_VALID, DONE not set, NSTEP1 held.
  - ABORT and START in the same IDLE cycle: ABORT wins, START is dropped.
- NSTEP1 changes only on the cycle REGEN_RST rises, so the regenerator never sees a phase change without a reset.
- Worst-case scan length per step: RST_LEN + max(DWELL,1) + 1 cycles.

Optional Feature:
PHASE_SCAN_LOOP_EN
- Defined: FINISH is skipped when the range is exhausted (ERR path unchanged). ADVANCE reloads NSTEP1=STEP_MIN and STEP_IDX=0, asserts REGEN_RST, and the scan repeats until ABORT. DONE is never set on that path.
- Undefined: single-pass behaviour as above.

Decomposition:
- Shared package phase_scan_pkg: state enum (IDLE, RST_PULSE, SETTLE, ADVANCE, FINISH), STEP_W=6, default RST_LEN, default DWELL_W.
- One natural sub-module, scan_dwell_timer: loadable down-counter with terminal-count output, reused for both the RST_PULSE and SETTLE phases.

Test Plan:
- MIN=2, MAX=10, INC=4, DWELL=8, RST_LEN=4, START -> NSTEP1 sequence 2,6,10. Three STEP_VALID pulses, 13 cycles apart. DONE=1 and BUSY=0 after the third step.
- MIN=60, MAX=63, INC=5 -> single step at 60 (65 overflows the range), then DONE.
- MIN=9, MAX=3 -> ERR=1, DONE=1 within 2 cycles, REGEN_RST never asserted.
- INC=0, DWELL=0, MIN=0, MAX=2 -> steps 0,1,2, each settle lasting 1 cycle.
- ABORT during the second SETTLE -> BUSY=0 next cycle, no further STEP_VALID, DONE=0, NSTEP1 held at the second value. START pulsed while BUSY is ignored.
- With PHASE_SCAN_LOOP_EN: MIN=1, MAX=3, INC=1 -> NSTEP1 sequence 1,2,3,1,2,... with DONE=0. RST_IN mid-scan -> all outputs 0 next cycle.
